// File: rtl/reg_bank.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | reg_bank: twelve general registers written from the C bus, with optional    |
// | increment port (macro REG_BANK_INC_EN). Rev 1.0                             |
// +----------------------------------------------------------------------------+
module reg_bank #(
  parameter int WIDTH = 19,
  parameter int NREG  = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] c_bus,
  input  logic [3:0]       c_sel,
  input  logic [3:0]       inc_sel,
  output logic [WIDTH-1:0] R0,
  output logic [WIDTH-1:0] R1,
  output logic [WIDTH-1:0] R2,
  output logic [WIDTH-1:0] R3,
  output logic [WIDTH-1:0] R4,
  output logic [WIDTH-1:0] R5,
  output logic [WIDTH-1:0] R6,
  output logic [WIDTH-1:0] R7,
  output logic [WIDTH-1:0] R8,
  output logic [WIDTH-1:0] R9,
  output logic [WIDTH-1:0] R10,
  output logic [WIDTH-1:0] R11,
  output logic             wr_ack
);

  localparam logic [3:0] C_FIRST = 4'd2;
  localparam logic [3:0] C_LAST  = 4'(NREG + 1);

  logic [WIDTH-1:0] w_regs [NREG];
  logic             w_c_hit;
  logic             w_inc_hit;
  logic             r_ack;

  assign w_c_hit = (c_sel >= C_FIRST) && (c_sel <= C_LAST);

`ifdef REG_BANK_INC_EN
  assign w_inc_hit = (inc_sel >= C_FIRST) && (inc_sel <= C_LAST);
`else
  logic unused_inc_sel;
  assign unused_inc_sel = ^inc_sel;
  assign w_inc_hit      = 1'b0;
`endif

  for (genvar i = 0; i < NREG; i++) begin : g_reg
    localparam logic [3:0] C_CODE = 4'(i + 2);
    logic [WIDTH-1:0] r_val;

    // The C bus write is tested first so it wins a collision with increment.
    always_ff @(posedge clk) begin
      if (rst) begin
        r_val <= '0;
      end else if (c_sel == C_CODE) begin
        r_val <= c_bus;
`ifdef REG_BANK_INC_EN
      end else if (inc_sel == C_CODE) begin
        r_val <= r_val + WIDTH'(1);
`endif
      end
    end

    assign w_regs[i] = r_val;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ack <= 1'b0;
    end else begin
      r_ack <= w_c_hit || w_inc_hit;
    end
  end

  assign wr_ack = r_ack;
  assign R0     = w_regs[0];
  assign R1     = w_regs[1];
  assign R2     = w_regs[2];
  assign R3     = w_regs[3];
  assign R4     = w_regs[4];
  assign R5     = w_regs[5];
  assign R6     = w_regs[6];
  assign R7     = w_regs[7];
  assign R8     = w_regs[8];
  assign R9     = w_regs[9];
  assign R10    = w_regs[10];
  assign R11    = w_regs[11];

endmodule
`default_nettype wire

// File: tb/tb_reg_bank.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_reg_bank: directed and random stimulus checked against an array model.   |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module tb_reg_bank;

  localparam int          WIDTH = 19;
  localparam int          NREG  = 12;
  localparam int unsigned MASK  = (1 << WIDTH) - 1;
`ifdef REG_BANK_INC_EN
  localparam bit INC_EN = 1'b1;
`else
  localparam bit INC_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic [WIDTH-1:0] c_bus;
  logic [3:0]       c_sel;
  logic [3:0]       inc_sel;
  logic [WIDTH-1:0] R0, R1, R2, R3, R4, R5, R6, R7, R8, R9, R10, R11;
  logic             wr_ack;
  logic [WIDTH-1:0] dut_r [NREG];

  int unsigned model_r [NREG];
  int unsigned model_ack;
  int          n_total = 0;
  int          n_bad   = 0;

  always #5 clk = ~clk;

  reg_bank #(.WIDTH(WIDTH), .NREG(NREG)) dut (
    .clk(clk), .rst(rst), .c_bus(c_bus), .c_sel(c_sel), .inc_sel(inc_sel),
    .R0(R0), .R1(R1), .R2(R2), .R3(R3), .R4(R4), .R5(R5), .R6(R6), .R7(R7),
    .R8(R8), .R9(R9), .R10(R10), .R11(R11), .wr_ack(wr_ack)
  );

  assign dut_r[0]  = R0;
  assign dut_r[1]  = R1;
  assign dut_r[2]  = R2;
  assign dut_r[3]  = R3;
  assign dut_r[4]  = R4;
  assign dut_r[5]  = R5;
  assign dut_r[6]  = R6;
  assign dut_r[7]  = R7;
  assign dut_r[8]  = R8;
  assign dut_r[9]  = R9;
  assign dut_r[10] = R10;
  assign dut_r[11] = R11;

  task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Register file semantics: reset clears everything; otherwise the increment
  // applies first and a C bus write to the same register overrides it.
  task automatic model_update(input logic r, input logic [3:0] cs,
                              input logic [WIDTH-1:0] cb, input logic [3:0] is);
    bit c_ok;
    bit i_ok;
    if (r) begin
      for (int i = 0; i < NREG; i++) model_r[i] = 0;
      model_ack = 0;
    end else begin
      c_ok = (cs >= 2) && (cs <= 13);
      i_ok = INC_EN && (is >= 2) && (is <= 13);
      if (i_ok) model_r[int'(is) - 2] = (model_r[int'(is) - 2] + 1) & MASK;
      if (c_ok) model_r[int'(cs) - 2] = int'(cb);
      model_ack = (c_ok || i_ok) ? 1 : 0;
    end
  endtask

  task automatic compare_all();
    for (int i = 0; i < NREG; i++) chk($sformatf("R%0d", i), int'(dut_r[i]), model_r[i]);
    chk("wr_ack", int'(wr_ack), model_ack);
  endtask

  task automatic step(input logic r, input logic [3:0] cs,
                      input logic [WIDTH-1:0] cb, input logic [3:0] is);
    rst     = r;
    c_sel   = cs;
    c_bus   = cb;
    inc_sel = is;
    @(posedge clk);
    model_update(r, cs, cb, is);
    #1;
    compare_all();
  endtask

  initial begin
    rst = 1'b1; c_sel = 4'd0; c_bus = '0; inc_sel = 4'd0;
    for (int i = 0; i < NREG; i++) model_r[i] = 0;
    model_ack = 0;

    // Reset then two writes
    step(1'b1, 4'd0, 19'd0, 4'd0);
    step(1'b1, 4'd0, 19'd0, 4'd0);
    chk("reset_r0", int'(R0), 0);
    chk("reset_ack", int'(wr_ack), 0);
    step(1'b0, 4'd2, 19'd3, 4'd0);
    chk("first_wr_r0", int'(R0), 3);
    step(1'b0, 4'd13, 19'd14, 4'd0);
    chk("wr_r11", int'(R11), 14);
    step(1'b0, 4'd0, 19'd0, 4'd0);

    // Full sweep, then the non-storing codes
    for (int k = 2; k <= 13; k++) step(1'b0, 4'(k), 19'(k + 1), 4'd0);
    foreach (dut_r[i]) chk($sformatf("sweep_R%0d", i), int'(dut_r[i]), i + 3);
    step(1'b0, 4'd0, 19'h55, 4'd0);
    step(1'b0, 4'd1, 19'h55, 4'd0);
    step(1'b0, 4'd14, 19'h55, 4'd0);
    step(1'b0, 4'd15, 19'h55, 4'd0);
    chk("nowrite_ack", int'(wr_ack), 0);
    chk("nowrite_r11", int'(R11), 14);

    // Increment wrap on R5
    step(1'b0, 4'd7, 19'h7FFFE, 4'd0);
    step(1'b0, 4'd0, 19'd0, 4'd7);
    chk("inc_r5", int'(R5), INC_EN ? 32'h7FFFF : 32'h7FFFE);
    step(1'b0, 4'd0, 19'd0, 4'd7);
    chk("wrap_r5", int'(R5), INC_EN ? 32'h0 : 32'h7FFFE);

    // Collision and split targets
    step(1'b0, 4'd5, 19'd5, 4'd0);
    step(1'b0, 4'd5, 19'd100, 4'd5);
    chk("collide_r3", int'(R3), 100);
    step(1'b0, 4'd3, 19'd4, 4'd0);
    step(1'b0, 4'd2, 19'd9, 4'd3);
    chk("split_r0", int'(R0), 9);
    chk("split_r1", int'(R1), INC_EN ? 5 : 4);

    // Reset wins over a simultaneous write
    step(1'b1, 4'd4, 19'd77, 4'd4);
    chk("rst_mid_r2", int'(R2), 0);
    chk("rst_mid_ack", int'(wr_ack), 0);
    step(1'b0, 4'd0, 19'd0, 4'd0);

    // Random traffic with occasional reset
    for (int n = 0; n < 400; n++) begin
      step(($urandom_range(0, 24) == 0) ? 1'b1 : 1'b0,
           4'($urandom_range(0, 15)),
           19'($urandom),
           4'($urandom_range(0, 15)));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/reg_bank.md
REG_BANK -- requirements
Module: reg_bank

Interface
- REQ-001 The block SHALL have parameter WIDTH, default 19, giving the data width of every register and of the C bus.
- REQ-002 The block SHALL have parameter NREG, default 12, giving the number of general registers R0..R(NREG-1); only 12 is supported.
- REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge only.
- REQ-004 rst  input  1  reset; synchronous and active-high.
- REQ-005 c_bus  input  WIDTH  write data from the ALU result bus.
- REQ-006 c_sel  input  4  write target; 2..13 selects R0..R11, the same codes the A bus uses for its sources. Codes 0, 1, 14 and 15 mean no write here.
- REQ-007 inc_sel  input  4  increment target, using the same encoding as c_sel.
- REQ-008 R0..R11  output  WIDTH each  register contents, driven straight from the flops with no combinational path from the inputs; these feed the A bus sources.
- REQ-009 wr_ack  output  1  high for one cycle after any accepted write or increment.

Function
- REQ-010 When c_sel is 2..13 at a rising edge, the selected register SHALL load c_bus, visible one cycle after c_sel is sampled.
- REQ-011 When inc_sel is 2..13 at a rising edge, the selected register SHALL load its own value + 1 modulo 2^WIDTH.
- REQ-012 Increment wrap-around: 19'h7FFFF + 1 SHALL give 19'h00000, with no flag or stall.
- REQ-013 If c_sel and inc_sel select different registers in the same cycle, both updates SHALL occur in that cycle.
- REQ-014 If c_sel and inc_sel select the same register, the c_bus write SHALL win and the increment SHALL be discarded.
- REQ-015 Registers that are not selected SHALL hold their value.
- REQ-016 c_sel codes 0, 1, 14 and 15 SHALL leave every register unchanged; DMAR and DMDR are not stored in this block.
- REQ-017 wr_ack SHALL be registered and SHALL be 1 in the cycle after a cycle in which c_sel or inc_sel is 2..13; otherwise it SHALL be 0.
- REQ-018 The block SHALL have no combinational path from any input to any output.

Reset
- REQ-019 When rst is high at a rising edge, R0..R11 SHALL be 0 and wr_ack SHALL be 0 in the following cycle.
- REQ-020 rst SHALL take priority over any write or increment sampled in the same cycle; those operations are lost.
- REQ-021 Asserting rst in the middle of a sequence of operations SHALL abort it, and no operation sampled during reset SHALL take effect afterwards.
- REQ-022 The first write SHALL be accepted at the first rising edge at which rst is low.

Configuration
- REQ-023 Macro REG_BANK_INC_EN: when defined, increment SHALL behave as REQ-011 to REQ-014.
- REQ-024 When REG_BANK_INC_EN is not defined:
  - the inc_sel port SHALL remain present but be ignored;
  - no adder logic SHALL be built;
  - wr_ack SHALL reflect only c_sel.

Verification
- REQ-025 Reset then write: rst for 2 cycles, then c_sel = 2 with c_bus = 3, then c_sel = 13 with c_bus = 14 -> R0 = 3 and R11 = 14 one cycle after each, all other registers 0, wr_ack pulses twice.
- REQ-026 Full sweep: c_sel = 2..13 on successive cycles with c_bus = 3..14 -> R0..R11 = 3..14; then c_sel = 0, 1, 14, 15 -> no change and wr_ack = 0.
- REQ-027 Increment wrap: R5 = 19'h7FFFE, then inc_sel = 7 for 2 cycles -> R5 = 19'h7FFFF, then 19'h00000. With the macro undefined, R5 stays at 19'h7FFFE.
- REQ-028 Collision: R3 = 5, then c_sel = 5 with c_bus = 100 and inc_sel = 5 in the same cycle -> R3 = 100. Different targets in one cycle (c_sel = 2 with c_bus = 9, inc_sel = 3 with R1 = 4) -> R0 = 9 and R1 = 5.
- REQ-029 Reset mid-operation: rst asserted in the same cycle as c_sel = 4 with c_bus = 77 -> R2 = 0 and wr_ack = 0 afterwards.
- REQ-030 Every check SHALL compare all 12 outputs against a reference model on every cycle.
